fft_bar_hold: RTL and testbench

FFT_BAR_HOLD -- requirements
Module: fft_bar_hold

---
 rtl/fft_bar_hold.sv | 174 +++++++++++++++++
 tb/tb_fft_bar_hold.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bar_hold.sv
// Per-bin bar/peak-hold store for a spectrum display: each request runs a read-modify-write
// of one bin. A clear request, or reset, runs a zeroing sweep over every bin.
module fft_bar_hold #(
    parameter int unsigned bw_bin      = 5,
    parameter int unsigned hold_frames = 15,
    parameter int unsigned fall_step   = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [6:0]        In,
    input  logic [bw_bin-1:0] Bin,
    input  logic              Clear,
    input  logic [bw_bin-1:0] RdAddr,
    output logic [6:0]        RdBar,
    output logic [6:0]        RdPeak,
    output logic              Busy,
    output logic              End
);

    localparam int unsigned       Depth    = 1 << bw_bin;
    localparam logic [bw_bin-1:0] LastAddr = bw_bin'(Depth - 1);
    localparam logic [6:0]        MaxBar   = 7'd96;
    localparam logic [6:0]        FallStep = 7'(fall_step);
    localparam logic [3:0]        HoldInit = 4'(hold_frames);

    typedef enum logic [2:0] {IDLE, RD, UPD, WR, CLR} stateType;

    stateType          state, stateNext;
    logic [bw_bin-1:0] clrAddr, clrAddrNext;
    logic [bw_bin-1:0] binQ;
    logic [6:0]        inQ;
    logic [6:0]        barQ, peakQ;
    logic [3:0]        holdQ;
    logic [6:0]        newBarQ, newPeakQ;
    logic [3:0]        newHoldQ;
    logic              busyNext, endNext, latch;

    logic              memWe;
    logic [bw_bin-1:0] memAddr;
    logic [6:0]        memBar, memPeak;
    logic [3:0]        memHold;

    logic [6:0] barMem  [Depth];
    logic [6:0] peakMem [Depth];
    logic [3:0] holdMem [Depth];

    logic [6:0] barDec, peakDec, newBar, newPeak;
    logic [3:0] newHold;

    // Reset lands in CLR so the first thing after reset is a full zeroing sweep
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= CLR;
            clrAddr <= '0;
            Busy    <= 1'b1;
            End     <= 1'b0;
        end else begin
            state   <= stateNext;
            clrAddr <= clrAddrNext;
            Busy    <= busyNext;
            End     <= endNext;
        end
    end

    always_comb begin
        stateNext   = state;
        clrAddrNext = clrAddr;
        busyNext    = Busy;
        endNext     = 1'b0;
        latch       = 1'b0;
        memWe       = 1'b0;
        memAddr     = binQ;
        memBar      = newBarQ;
        memPeak     = newPeakQ;
        memHold     = newHoldQ;
        case (state)
            IDLE: begin
                if (Clear) begin
                    stateNext   = CLR;
                    clrAddrNext = '0;
                    busyNext    = 1'b1;
                end else if (Start) begin
                    stateNext = RD;
                    latch     = 1'b1;
                    busyNext  = 1'b1;
                end
            end
            RD:  stateNext = UPD;
            UPD: stateNext = WR;
            WR: begin
                memWe     = 1'b1;
                endNext   = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            CLR: begin
                memWe   = 1'b1;
                memAddr = clrAddr;
                memBar  = '0;
                memPeak = '0;
                memHold = '0;
                if (clrAddr == LastAddr) begin
                    endNext   = 1'b1;
                    busyNext  = 1'b0;
                    stateNext = IDLE;
                end else begin
                    clrAddrNext = bw_bin'(clrAddr + 1'b1);
                end
            end
            default: stateNext = CLR;
        endcase
    end

    // Bar falls by FallStep but never below the new input; peak decays only after the hold expires
    always_comb begin
        barDec  = (barQ > FallStep) ? 7'(barQ - FallStep) : 7'd0;
        peakDec = (peakQ != 7'd0) ? 7'(peakQ - 7'd1) : 7'd0;
        if (inQ >= barQ)
            newBar = inQ;
        else
            newBar = (inQ > barDec) ? inQ : barDec;
        newPeak = peakQ;
        newHold = holdQ;
        if (inQ >= peakQ) begin
            newPeak = inQ;
            newHold = HoldInit;
        end else if (holdQ != 4'd0) begin
            newHold = 4'(holdQ - 4'd1);
        end else begin
            newPeak = (newBar > peakDec) ? newBar : peakDec;
            newHold = 4'd0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            binQ     <= '0;
            inQ      <= '0;
            newBarQ  <= '0;
            newPeakQ <= '0;
            newHoldQ <= '0;
            RdBar    <= '0;
            RdPeak   <= '0;
        end else begin
            if (latch) begin
                binQ <= Bin;
                inQ  <= (In > MaxBar) ? MaxBar : In;
            end
            if (state == UPD) begin
                newBarQ  <= newBar;
                newPeakQ <= newPeak;
                newHoldQ <= newHold;
            end
            RdBar  <= barMem[RdAddr];
            RdPeak <= peakMem[RdAddr];
        end
    end

    // Storage is not reset; reads see pre-write contents on a same-edge collision
    always_ff @(posedge Clock) begin
        if (state == RD) begin
            barQ  <= barMem[binQ];
            peakQ <= peakMem[binQ];
            holdQ <= holdMem[binQ];
        end
        if (memWe) begin
            barMem[memAddr]  <= memBar;
            peakMem[memAddr] <= memPeak;
            holdMem[memAddr] <= memHold;
        end
    end

endmodule

// File: tb/tb_fft_bar_hold.sv
// Bench for fft_bar_hold: table vectors, a randomized run against a per-bin model, and reset/clear corners.
module tb_fft_bar_hold;

    logic       Clock = 1'b0;
    logic       Reset, Start, Clear;
    logic [6:0] In;
    logic [4:0] Bin, RdAddr;
    logic [6:0] RdBar, RdPeak;
    logic       Busy, End;

    int passCount = 0;
    int checkCount = 0;
    int refBar [32];
    int refPeak[32];
    int refHold[32];

    typedef struct {
        int bin;
        int inVal;
        int expBar;
        int expPeak;
    } vecT;

    vecT vecs[18];

    fft_bar_hold dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .In    (In),
        .Bin   (Bin),
        .Clear (Clear),
        .RdAddr(RdAddr),
        .RdBar (RdBar),
        .RdPeak(RdPeak),
        .Busy  (Busy),
        .End   (End)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void modelClear();
        for (int i = 0; i < 32; i++) begin
            refBar[i] = 0;
            refPeak[i] = 0;
            refHold[i] = 0;
        end
    endfunction

    // Bar/peak behaviour written directly from the display rules with integer arithmetic
    function automatic void modelUpdate(input int b, input int x);
        int v;
        int nb;
        v  = (x > 96) ? 96 : x;
        nb = (v >= refBar[b]) ? v : ((refBar[b] - 3 > v) ? refBar[b] - 3 : v);
        if (v >= refPeak[b]) begin
            refPeak[b] = v;
            refHold[b] = 15;
        end else if (refHold[b] > 0) begin
            refHold[b] = refHold[b] - 1;
        end else begin
            refPeak[b] = (nb > refPeak[b] - 1) ? nb : refPeak[b] - 1;
        end
        refBar[b] = nb;
    endfunction

    task automatic readBin(input int a, output int bar, output int peak);
        RdAddr = 5'(a);
        tick;
        bar  = int'(RdBar);
        peak = int'(RdPeak);
    endtask

    task automatic waitSweep(input string tag);
        int cycles;
        bit seen;
        bit busyDrop;
        cycles = 0;
        seen = 0;
        busyDrop = 0;
        while (!seen && cycles < 100) begin
            tick;
            cycles++;
            if (End) seen = 1;
            else if (!Busy) busyDrop = 1;
        end
        check({tag, " sweep cycles"}, cycles, 32);
        check({tag, " busy held"}, int'(busyDrop), 0);
        check({tag, " busy low at end"}, int'(Busy), 0);
        tick;
        check({tag, " end one cycle"}, int'(End), 0);
        modelClear();
    endtask

    task automatic doUpdate(input int b, input int x, input string tag);
        int edges;
        bit seen;
        int oldBar;
        oldBar = refBar[b];
        RdAddr = 5'(b);
        Start = 1'b1;
        In = 7'(x);
        Bin = 5'(b);
        tick;
        Start = 1'b0;
        check({tag, " busy"}, int'(Busy), 1);
        edges = 0;
        seen = 0;
        while (!seen && edges < 10) begin
            tick;
            edges++;
            if (End) seen = 1;
        end
        check({tag, " latency"}, edges, 3);
        check({tag, " old data on collision"}, int'(RdBar), oldBar);
        check({tag, " busy after"}, int'(Busy), 0);
        tick;
        check({tag, " end pulse width"}, int'(End), 0);
        modelUpdate(b, x);
    endtask

    initial begin
        int bar, peak, ends, b, x, a;

        vecs[0] = '{3, 50, 50, 50};
        for (int k = 1; k <= 16; k++)
            vecs[k] = '{3, 10, (50 - 3 * k < 10) ? 10 : 50 - 3 * k, (k < 16) ? 50 : 49};
        vecs[17] = '{0, 120, 96, 96};

        Reset = 1'b1;
        Start = 1'b0;
        Clear = 1'b0;
        In = '0;
        Bin = '0;
        RdAddr = '0;
        modelClear();
        repeat (3) tick;
        check("reset busy", int'(Busy), 1);
        check("reset end", int'(End), 0);
        check("reset rdbar", int'(RdBar), 0);
        check("reset rdpeak", int'(RdPeak), 0);
        Reset = 1'b0;
        waitSweep("post-reset");
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 0 : ((i == 1) ? 17 : 31);
            readBin(a, bar, peak);
            check($sformatf("swept bar[%0d]", a), bar, 0);
            check($sformatf("swept peak[%0d]", a), peak, 0);
        end

        // Table: attack, fall with peak hold, peak decay, input clamp
        for (int i = 0; i < 18; i++) begin
            doUpdate(vecs[i].bin, vecs[i].inVal, $sformatf("vec%0d", i));
            readBin(vecs[i].bin, bar, peak);
            check($sformatf("vec%0d bar", i), bar, vecs[i].expBar);
            check($sformatf("vec%0d peak", i), peak, vecs[i].expPeak);
            check($sformatf("vec%0d model bar", i), bar, refBar[vecs[i].bin]);
        end

        // Start and Clear while busy must be dropped
        RdAddr = 5'd5;
        Start = 1'b1;
        In = 7'd30;
        Bin = 5'd5;
        tick;
        Start = 1'b1;
        Clear = 1'b1;
        In = 7'd40;
        Bin = 5'd6;
        tick;
        Start = 1'b0;
        Clear = 1'b0;
        ends = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (End) ends++;
        end
        check("busy-ignore end count", ends, 1);
        modelUpdate(5, 30);
        readBin(5, bar, peak);
        check("busy-ignore bin5 bar", bar, refBar[5]);
        readBin(6, bar, peak);
        check("busy-ignore bin6 bar", bar, refBar[6]);
        readBin(0, bar, peak);
        check("busy-ignore bin0 kept", bar, 96);

        // Clear from IDLE zeroes everything
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        check("clear busy", int'(Busy), 1);
        waitSweep("clear");
        for (int i = 0; i < 32; i++) begin
            readBin(i, bar, peak);
            check($sformatf("cleared bar[%0d]", i), bar, 0);
            check($sformatf("cleared peak[%0d]", i), peak, 0);
        end

        // Random traffic on a few bins so holds expire and peaks decay
        for (int i = 0; i < 60; i++) begin
            b = int'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 40));
            doUpdate(b, x, $sformatf("rnd%0d", i));
            readBin(b, bar, peak);
            check($sformatf("rnd%0d bar", i), bar, refBar[b]);
            check($sformatf("rnd%0d peak", i), peak, refPeak[b]);
        end

        // Reset one cycle after Start aborts the update
        doUpdate(3, 60, "pre-abort");
        Start = 1'b1;
        In = 7'd90;
        Bin = 5'd3;
        tick;
        Start = 1'b0;
        tick;
        Reset = 1'b1;
        #1;
        check("abort end", int'(End), 0);
        check("abort busy", int'(Busy), 1);
        tick;
        Reset = 1'b0;
        waitSweep("abort");
        readBin(3, bar, peak);
        check("abort bin3 bar", bar, 0);
        check("abort bin3 peak", peak, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
